// File: rtl/pir_pkg.sv
// Shared PIR scan definitions: one-hot FSM encoding, channel index type and
// the default motion threshold that the alarm FSM also uses.
package pir_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        SETTLE = 5'b00010,
        REQ    = 5'b00100,
        NEXT   = 5'b01000,
        COMMIT = 5'b10000
    } state_t;

    typedef logic [1:0] ch_t;

    localparam int PIR_THRESHOLD = 50;

endpackage

// File: rtl/pir_motion_cmp.sv
// Per-channel motion compare. With PIR_SCAN_HYST_EN defined the flag sets at
// THRESHOLD and only clears below THRESHOLD-HYST (floored at 0).
module pir_motion_cmp
    import pir_pkg::*;
#(
    parameter int DATA_W    = 7,
    parameter int THRESHOLD = PIR_THRESHOLD
`ifdef PIR_SCAN_HYST_EN
    ,
    parameter int HYST      = 8
`endif
) (
    input  logic [DATA_W-1:0] sample,
`ifdef PIR_SCAN_HYST_EN
    input  logic              prev,
`endif
    output logic              hit
);

`ifdef PIR_SCAN_HYST_EN
    localparam int LOW = (THRESHOLD > HYST) ? (THRESHOLD - HYST) : 0;

    always_comb begin
        hit = prev;
        if (sample >= DATA_W'(THRESHOLD))
            hit = 1'b1;
        else if (sample < DATA_W'(LOW))
            hit = 1'b0;
    end
`else
    always_comb begin
        hit = (sample >= DATA_W'(THRESHOLD));
    end
`endif

endmodule

// File: rtl/pir_scan_scheduler.sv
// Round-robin scheduler sharing one PIR ADC across three channels; publishes a
// frame per round. Optional hysteresis on motion flags via PIR_SCAN_HYST_EN.
module pir_scan_scheduler
    import pir_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int DATA_W        = 7,
    parameter int THRESHOLD     = PIR_THRESHOLD,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACK_TIMEOUT   = 15
`ifdef PIR_SCAN_HYST_EN
    ,
    parameter int HYST          = 8
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     turn,
    output logic [1:0]               adc_sel,
    output logic                     adc_req,
    input  logic                     adc_ack,
    input  logic [DATA_W-1:0]        adc_data,
    output logic [NUM_CH*DATA_W-1:0] frame_data,
    output logic                     frame_valid,
    output logic [NUM_CH-1:0]        motion,
    output logic [NUM_CH-1:0]        timeout_err,
    output logic                     busy
);

    localparam int  SCNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int  TCNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam ch_t LAST_CH = ch_t'(NUM_CH - 1);

    state_t                     state, state_nxt;
    ch_t                        ch;
    logic [SCNT_W-1:0]          scnt;
    logic [TCNT_W-1:0]          tcnt;
    logic [NUM_CH*DATA_W-1:0]   shadow;
    logic [NUM_CH-1:0]          mot_nxt;
    logic                       ack_take, tout_hit, commit;

    assign adc_sel     = ch;
    assign adc_req     = (state == REQ);
    assign frame_valid = (state == COMMIT);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        ack_take  = 1'b0;
        tout_hit  = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE:   if (turn) state_nxt = SETTLE;
            SETTLE: if (scnt == SCNT_W'(SETTLE_CYCLES - 1)) state_nxt = REQ;
            REQ: begin
                // An ack in the expiry cycle still counts as a good conversion.
                if (adc_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = NEXT;
                end else if (tcnt == TCNT_W'(ACK_TIMEOUT - 1)) begin
                    tout_hit  = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                commit    = (ch == LAST_CH);
                state_nxt = commit ? COMMIT : SETTLE;
            end
            COMMIT: state_nxt = turn ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch          <= '0;
            scnt        <= '0;
            tcnt        <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            motion      <= '0;
            timeout_err <= '0;
        end else begin
            scnt <= (state == SETTLE && state_nxt == SETTLE) ? scnt + SCNT_W'(1) : '0;
            tcnt <= (state == REQ && state_nxt == REQ) ? tcnt + TCNT_W'(1) : '0;

            if (state == NEXT && ch != LAST_CH)
                ch <= ch + ch_t'(1);
            else if (state == COMMIT)
                ch <= '0;

            for (int i = 0; i < NUM_CH; i++) begin
                if (ch == ch_t'(i)) begin
                    if (ack_take)
                        shadow[i*DATA_W +: DATA_W] <= adc_data;
                    else if (tout_hit)
                        shadow[i*DATA_W +: DATA_W] <= '0;
                    if (tout_hit)
                        timeout_err[i] <= 1'b1;
                end
            end

            // Frame registers load on COMMIT entry so they are valid with the pulse.
            if (commit) begin
                frame_data <= shadow;
                motion     <= mot_nxt;
            end

            if (state == IDLE && !turn)
                timeout_err <= '0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
        pir_motion_cmp #(
            .DATA_W    (DATA_W),
            .THRESHOLD (THRESHOLD)
`ifdef PIR_SCAN_HYST_EN
            ,
            .HYST      (HYST)
`endif
        ) u_cmp (
            .sample (shadow[g*DATA_W +: DATA_W]),
`ifdef PIR_SCAN_HYST_EN
            .prev   (motion[g]),
`endif
            .hit    (mot_nxt[g])
        );
    end

endmodule
